vga_fb_rect_writer: RTL and testbench

//  Write-side client of the VGA frame buffer (8-bit colour index per pixel, 640x480).

---
 rtl/vga_fb_rect_writer.sv | 161 ++++++++++++++++
 tb/tb_vga_fb_rect_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_rect_writer.sv
// rtl/vga_fb_rect_writer.sv - clipped rectangle-fill writer for the VGA frame buffer
//
// Accepts one rectangle command (x, y, w, h, colour) and clips it to the screen.
// It then streams one pixel write per clock, in raster order, on the frame buffer's user write port.
//
// Ports:
//   iclk        frame-buffer write clock
//   irst        asynchronous active-high reset
//   icmd_valid  command valid; accepted with ocmd_ready at the rising edge
//   ocmd_ready  high only in IDLE
//   ix, iy      rectangle top-left corner
//   iw, ih      rectangle size in pixels
//   icolor      colour index to fill with
//   oaddr       registered write address, row*H_RES + col
//   odata       registered write data
//   owren       registered write enable, one pixel per high cycle
//   obusy       high in every state except IDLE
//   odone       one-cycle pulse when a command completes, empty commands included
module vga_fb_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              icmd_valid,
    output logic              ocmd_ready,
    input  logic [9:0]        ix,
    input  logic [8:0]        iy,
    input  logic [9:0]        iw,
    input  logic [8:0]        ih,
    input  logic [DATA_W-1:0] icolor,
    output logic [ADDR_W-1:0] oaddr,
    output logic [DATA_W-1:0] odata,
    output logic              owren,
    output logic              obusy,
    output logic              odone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [10:0]       X_LIM      = 11'(H_RES);
    localparam logic [9:0]        Y_LIM      = 10'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES);

    state_t state, state_n;

    logic [9:0]        x_r;
    logic [8:0]        y_r;
    logic [9:0]        w_r;
    logic [8:0]        h_r;
    logic [DATA_W-1:0] color_r;
    logic [10:0]       xe;
    logic [9:0]        ye;
    logic [9:0]        col;
    logic [8:0]        row;
    logic [ADDR_W-1:0] base;

    // Exclusive right/bottom edges, clipped to the screen. The widened sums cannot overflow.
    logic [10:0] x_sum;
    logic [9:0]  y_sum;
    logic [10:0] xe_c;
    logic [9:0]  ye_c;
    logic        empty;
    logic        col_last;
    logic        row_last;
    logic        accept;

    assign x_sum    = {1'b0, x_r} + {1'b0, w_r};
    assign y_sum    = {1'b0, y_r} + {1'b0, h_r};
    assign xe_c     = (x_sum > X_LIM) ? X_LIM : x_sum;
    assign ye_c     = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    assign empty    = (w_r == 10'd0) || (h_r == 9'd0) ||
                      ({1'b0, x_r} >= X_LIM) || ({1'b0, y_r} >= Y_LIM);
    assign col_last = ({1'b0, col} == (xe - 11'd1));
    assign row_last = ({1'b0, row} == (ye - 10'd1));

    assign ocmd_ready = (state == IDLE);
    assign obusy      = (state != IDLE);
    assign accept     = icmd_valid && ocmd_ready;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = CLIP;
            CLIP: state_n = empty ? DONE : FILL;
            FILL: if (col_last && row_last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered.
    // Each FILL cycle therefore appears on the write port one clock later.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            x_r     <= '0;
            y_r     <= '0;
            w_r     <= '0;
            h_r     <= '0;
            color_r <= '0;
            xe      <= '0;
            ye      <= '0;
            col     <= '0;
            row     <= '0;
            base    <= '0;
            oaddr   <= '0;
            odata   <= '0;
            owren   <= 1'b0;
            odone   <= 1'b0;
        end else begin
            owren <= (state == FILL);
            odone <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_r     <= ix;
                        y_r     <= iy;
                        w_r     <= iw;
                        h_r     <= ih;
                        color_r <= icolor;
                    end
                end
                CLIP: begin
                    xe   <= xe_c;
                    ye   <= ye_c;
                    col  <= x_r;
                    row  <= y_r;
                    base <= ADDR_W'(y_r) * ROW_STRIDE;
                end
                FILL: begin
                    oaddr <= base + ADDR_W'(col);
                    odata <= color_r;
                    if (col_last) begin
                        col  <= x_r;
                        row  <= row + 9'd1;
                        base <= base + ROW_STRIDE;
                    end else begin
                        col <= col + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_rect_writer.sv
// tb/tb_vga_fb_rect_writer.sv - directed self-checking bench for vga_fb_rect_writer
module tb_vga_fb_rect_writer;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        icmd_valid = 1'b0;
    logic        ocmd_ready;
    logic [9:0]  ix = '0;
    logic [8:0]  iy = '0;
    logic [9:0]  iw = '0;
    logic [8:0]  ih = '0;
    logic [7:0]  icolor = '0;
    logic [18:0] oaddr;
    logic [7:0]  odata;
    logic        owren;
    logic        obusy;
    logic        odone;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int max_addr = 0;

    int          wr_cyc[$];
    logic [18:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          done_cyc[$];

    vga_fb_rect_writer dut (
        .iclk       (iclk),
        .irst       (irst),
        .icmd_valid (icmd_valid),
        .ocmd_ready (ocmd_ready),
        .ix         (ix),
        .iy         (iy),
        .iw         (iw),
        .ih         (ih),
        .icolor     (icolor),
        .oaddr      (oaddr),
        .odata      (odata),
        .owren      (owren),
        .obusy      (obusy),
        .odone      (odone)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin
        if (!irst) begin
            if (owren) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(oaddr);
                wr_data.push_back(odata);
                if (int'(oaddr) > max_addr) max_addr = int'(oaddr);
            end
            if (odone) done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();
        max_addr = 0;
    endtask

    task automatic send_cmd(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                            input logic [8:0] h, input logic [7:0] c, output int k);
        int t = 0;
        @(negedge iclk);
        while (!ocmd_ready && t < 100) begin
            @(negedge iclk);
            t++;
        end
        ix = x; iy = y; iw = w; ih = h; icolor = c;
        icmd_valid = 1'b1;
        k = cyc + 1;
        @(posedge iclk);
        #1 icmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int t = 0;
        while (done_cyc.size() < n && t < 300) begin
            @(negedge iclk);
            t++;
        end
        repeat (2) @(negedge iclk);
        #1 check(tag, done_cyc.size(), n);
    endtask

    logic [18:0] exp_a;
    int k, k2;

    initial begin
        repeat (3) @(negedge iclk);
        #1;
        check("rst_owren", owren, 0);
        check("rst_oaddr", oaddr, 0);
        check("rst_odata", odata, 0);
        check("rst_odone", odone, 0);
        check("rst_obusy", obusy, 0);
        check("rst_ready", ocmd_ready, 1);
        irst = 1'b0;

        // 1: single pixel
        clear_log();
        send_cmd(10'd0, 9'd0, 10'd1, 9'd1, 8'h2A, k);
        wait_done("t1_done_cnt", 1);
        check("t1_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("t1_addr", wr_addr[0], 0);
            check("t1_data", wr_data[0], 8'h2A);
            check("t1_first_cyc", wr_cyc[0], k + 2);
        end
        if (done_cyc.size() == 1) check("t1_done_cyc", done_cyc[0], k + 3);
        check("t1_ready", ocmd_ready, 1);
        check("t1_busy", obusy, 0);

        // 2: 3x2 rectangle
        clear_log();
        send_cmd(10'd10, 9'd2, 10'd3, 9'd2, 8'h05, k);
        wait_done("t2_done_cnt", 1);
        check("t2_nwr", wr_addr.size(), 6);
        if (wr_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                exp_a = (i < 3) ? 19'(1290 + i) : 19'(1930 + i - 3);
                check($sformatf("t2_addr%0d", i), wr_addr[i], exp_a);
                check($sformatf("t2_data%0d", i), wr_data[i], 8'h05);
                check($sformatf("t2_cyc%0d", i), wr_cyc[i], k + 2 + i);
            end
        end
        if (done_cyc.size() == 1) check("t2_done_cyc", done_cyc[0], k + 8);

        // 3: clipped at the bottom-right corner
        clear_log();
        send_cmd(10'd638, 9'd479, 10'd5, 9'd4, 8'h77, k);
        wait_done("t3_done_cnt", 1);
        check("t3_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("t3_addr0", wr_addr[0], 307198);
            check("t3_addr1", wr_addr[1], 307199);
        end
        check("t3_max_addr", max_addr, 307199);
        if (done_cyc.size() == 1) check("t3_done_cyc", done_cyc[0], k + 4);

        // 4: empty commands
        clear_log();
        send_cmd(10'd1, 9'd1, 10'd0, 9'd1, 8'h10, k);
        wait_done("t4a_done_cnt", 1);
        check("t4a_nwr", wr_addr.size(), 0);
        if (done_cyc.size() == 1) check("t4a_done_cyc", done_cyc[0], k + 2);
        clear_log();
        send_cmd(10'd640, 9'd0, 10'd8, 9'd8, 8'h11, k);
        wait_done("t4b_done_cnt", 1);
        check("t4b_nwr", wr_addr.size(), 0);
        if (done_cyc.size() == 1) check("t4b_done_cyc", done_cyc[0], k + 2);

        // 5: reset in the middle of a fill
        clear_log();
        send_cmd(10'd0, 9'd0, 10'd16, 9'd1, 8'h99, k);
        while (cyc < k + 4) @(negedge iclk);
        #1;
        check("t5_busy_mid", obusy, 1);
        check("t5_ready_mid", ocmd_ready, 0);
        irst = 1'b1;
        #1;
        check("t5_rst_owren", owren, 0);
        check("t5_rst_ready", ocmd_ready, 1);
        repeat (3) @(negedge iclk);
        check("t5_nwr_before", wr_addr.size(), 3);
        irst = 1'b0;
        clear_log();
        send_cmd(10'd5, 9'd0, 10'd1, 9'd1, 8'h3C, k);
        wait_done("t5_done_cnt", 1);
        check("t5_nwr_after", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("t5_addr", wr_addr[0], 5);
            check("t5_data", wr_data[0], 8'h3C);
        end

        // 6: icmd_valid held high with changing fields during a fill
        clear_log();
        @(negedge iclk);
        ix = 10'd0; iy = 9'd10; iw = 10'd4; ih = 9'd4; icolor = 8'h33;
        icmd_valid = 1'b1;
        @(posedge iclk);
        #1;
        k2 = 0;
        while (obusy && k2 < 100) begin
            @(negedge iclk);
            ix = 10'(cyc * 7); iy = 9'(cyc * 3); iw = 10'(cyc); ih = 9'(cyc + 1);
            icolor = 8'(cyc);
            k2++;
            #1;
        end
        ix = 10'd100; iy = 9'd20; iw = 10'd4; ih = 9'd4; icolor = 8'h44;
        @(posedge iclk);
        #1 icmd_valid = 1'b0;
        wait_done("t6_done_cnt", 2);
        check("t6_nwr", wr_addr.size(), 32);
        if (wr_addr.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                if (i < 16) begin
                    exp_a = 19'((10 + i / 4) * 640 + (i % 4));
                    check($sformatf("t6_addr%0d", i), wr_addr[i], exp_a);
                    check($sformatf("t6_data%0d", i), wr_data[i], 8'h33);
                end else begin
                    exp_a = 19'((20 + (i - 16) / 4) * 640 + 100 + ((i - 16) % 4));
                    check($sformatf("t6_addr%0d", i), wr_addr[i], exp_a);
                    check($sformatf("t6_data%0d", i), wr_data[i], 8'h44);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
